ptmch_spi_rx: RTL and testbench

SPI slave receive front-end for the ptmch trigger path. Synchronises the asynchronous SPI_CS/SPI_CLK/SPI_MOSI pins into the CLK160M domain and deserialises each 16-bit frame. Frames are validated by bit count and converted into a single-cycle register-write strobe (address + data) that feeds the trigger generator's configuration registers. Malformed frames are dropped and flagged.

---
 rtl/ptmch_pkg.sv | 29 ++
 rtl/ptmch_sync.sv | 36 +++
 rtl/ptmch_spi_rx.sv | 129 ++++++++++++
 tb/tb_ptmch_spi_rx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ptmch_pkg.sv
// Shared constants, state encoding and register map for the ptmch trigger path.
package ptmch_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 12;

  // Counter must hold FRAME_BITS+1 so an overrun never aliases a valid count.
  localparam int CNT_W = $clog2(FRAME_BITS + 2);

  // Cycles after reset release during which synchroniser output is not trusted.
  localparam int FLUSH_CYCLES = 4;
  localparam int FLUSH_W      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } rx_state_t;

  localparam logic [ADDR_W-1:0] REG_CTRL     = 4'h0;
  localparam logic [ADDR_W-1:0] REG_TRG_MASK = 4'h1;
  localparam logic [ADDR_W-1:0] REG_THRESH   = 4'h2;
  localparam logic [ADDR_W-1:0] REG_DELAY    = 4'h3;
  localparam logic [ADDR_W-1:0] REG_WIDTH    = 4'h4;
  localparam logic [ADDR_W-1:0] REG_PRESCALE = 4'h5;
  localparam logic [ADDR_W-1:0] REG_TEST     = 4'hF;

endpackage

// File: rtl/ptmch_sync.sv
// 2-FF synchroniser followed by a registered level and rise/fall pulses.
module ptmch_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, lvl_q, rise_q, fall_q;

  // Level and pulses update on the same edge so they stay aligned downstream.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      lvl_q  <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= async_i;
      s2_q   <= s1_q;
      lvl_q  <= s2_q;
      rise_q <= s2_q & ~lvl_q;
      fall_q <= ~s2_q & lvl_q;
    end
  end

  assign level_o = lvl_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ptmch_spi_rx.sv
// SPI mode-0 slave receiver: deserialises 16-bit frames into a register-write strobe.
module ptmch_spi_rx
  import ptmch_pkg::*;
(
  input  logic              CLK160M,
  input  logic              RESET,
  input  logic              SPI_CS,
  input  logic              SPI_CLK,
  input  logic              SPI_MOSI,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              FRM_ERR,
  output logic              BUSY,
  output rx_state_t         STATE_DBG
);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl_unused, sclk_rise, sclk_fall_unused;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  ptmch_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk_i(CLK160M), .rst_i(RESET), .async_i(SPI_CS),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  ptmch_sync #(.RST_VAL(1'b0)) u_sync_clk (
    .clk_i(CLK160M), .rst_i(RESET), .async_i(SPI_CLK),
    .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall_unused)
  );

  ptmch_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(CLK160M), .rst_i(RESET), .async_i(SPI_MOSI),
    .level_o(mosi_lvl), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  rx_state_t             state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FLUSH_W-1:0]    flush_q, flush_d;
  logic                  wr_en_q, wr_en_d;
  logic                  frm_err_q, frm_err_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;

  always_ff @(posedge CLK160M) begin
    if (RESET) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      flush_q   <= '0;
      wr_en_q   <= 1'b0;
      frm_err_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      flush_q   <= flush_d;
      wr_en_q   <= wr_en_d;
      frm_err_q <= frm_err_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    flush_d   = flush_q;
    wr_en_d   = 1'b0;
    frm_err_d = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;

    if (flush_q != FLUSH_W'(FLUSH_CYCLES)) begin
      // Synchroniser still settling: ignore pulses, decide IDLE/HOLD on the last cycle.
      flush_d = flush_q + 1'b1;
      state_d = IDLE;
      if (flush_q == FLUSH_W'(FLUSH_CYCLES - 1)) begin
        state_d = cs_lvl ? IDLE : HOLD;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            shift_d = '0;
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          // cs_rise wins over a coincident sclk_rise: frame judged on the prior count.
          if (cs_rise) begin
            state_d = IDLE;
            if (cnt_q == CNT_W'(FRAME_BITS)) begin
              wr_en_d = 1'b1;
              addr_d  = shift_q[FRAME_BITS-1 -: ADDR_W];
              data_d  = shift_q[DATA_W-1:0];
            end else begin
              frm_err_d = 1'b1;
            end
          end else if (sclk_rise) begin
            shift_d = {shift_q[FRAME_BITS-2:0], mosi_lvl};
            if (cnt_q != CNT_W'(FRAME_BITS + 1)) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (cs_rise) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign WR_EN     = wr_en_q;
  assign WR_ADDR   = addr_q;
  assign WR_DATA   = data_q;
  assign FRM_ERR   = frm_err_q;
  assign BUSY      = (state_q != IDLE);
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_ptmch_spi_rx.sv
// Directed bench for ptmch_spi_rx: SPI frames at 20 MHz, scoreboard of expected writes.
module tb_ptmch_spi_rx;
  import ptmch_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              spi_cs = 1'b1;
  logic              spi_clk = 1'b0;
  logic              spi_mosi = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              frm_err;
  logic              busy;
  rx_state_t         state_dbg;

  ptmch_spi_rx dut (
    .CLK160M  (clk),
    .RESET    (rst),
    .SPI_CS   (spi_cs),
    .SPI_CLK  (spi_clk),
    .SPI_MOSI (spi_mosi),
    .WR_EN    (wr_en),
    .WR_ADDR  (wr_addr),
    .WR_DATA  (wr_data),
    .FRM_ERR  (frm_err),
    .BUSY     (busy),
    .STATE_DBG(state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [FRAME_BITS-1:0] exp_q[$];
  logic [FRAME_BITS-1:0] exp_v;
  int wr_cnt  = 0;
  int err_cnt = 0;
  int wr_cyc  = 0;
  int t_rise  = 0;

  always @(negedge clk) begin
    if (wr_en | frm_err) check("wr_err_exclusive", 32'(wr_en & frm_err), 32'd0);
    if (frm_err) err_cnt++;
    if (wr_en) begin
      wr_cnt++;
      wr_cyc = cyc;
      check("busy_at_wr", 32'(busy), 32'd0);
      check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        check("wr_value", 32'({wr_addr, wr_data}), 32'(exp_v));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    tick(4);
  endtask

  task automatic cs_high(input int gap);
    spi_cs = 1'b1;
    t_rise = cyc;
    tick(gap);
  endtask

  // Shift nbits of val, MSB first; 4 cycles low (setup) and 4 cycles high per bit.
  task automatic spi_bits(input logic [31:0] val, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_mosi = val[i];
      tick(4);
      spi_clk = 1'b1;
      tick(4);
      spi_clk = 1'b0;
    end
    tick(4);
  endtask

  task automatic spi_frame(input logic [31:0] val, input int nbits, input int gap);
    cs_low();
    check("busy_in_frame", 32'(busy), 32'd1);
    spi_bits(val, nbits);
    cs_high(gap);
  endtask

  // ---------------- stimulus ----------------
  int wr0, err0;

  initial begin
    // Reset with CS idle high
    tick(3);
    rst = 1'b0;
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_frm_err", 32'(frm_err), 32'd0);
    check("rst_addr", 32'(wr_addr), 32'd0);
    check("rst_data", 32'(wr_data), 32'd0);
    tick(8);
    check("idle_after_flush", 32'(state_dbg), 32'(IDLE));

    // Single valid frame 0x3A5C, latency from CS rise to WR_EN
    wr0 = wr_cnt; err0 = err_cnt;
    exp_q.push_back(16'h3A5C);
    spi_frame(32'h3A5C, 16, 8);
    check("f1_wr_count", 32'(wr_cnt - wr0), 32'd1);
    check("f1_err_count", 32'(err_cnt - err0), 32'd0);
    check("f1_latency", 32'(wr_cyc - t_rise), 32'd4);
    check("f1_addr", 32'(wr_addr), 32'h3);
    check("f1_data", 32'(wr_data), 32'hA5C);
    check("f1_busy_after", 32'(busy), 32'd0);

    // Short frame (15 bits) then overrun frame (17 bits)
    wr0 = wr_cnt; err0 = err_cnt;
    spi_frame(32'h7FFF, 15, 8);
    check("short_err_count", 32'(err_cnt - err0), 32'd1);
    spi_frame(32'h1FFFF, 17, 8);
    check("long_err_count", 32'(err_cnt - err0), 32'd2);
    check("bad_wr_count", 32'(wr_cnt - wr0), 32'd0);
    check("bad_addr_hold", 32'(wr_addr), 32'h3);
    check("bad_data_hold", 32'(wr_data), 32'hA5C);

    // Reset mid-frame with CS held low: remainder of frame must be discarded
    wr0 = wr_cnt; err0 = err_cnt;
    cs_low();
    spi_bits(32'hAB, 8);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(6);
    check("hold_state", 32'(state_dbg), 32'(HOLD));
    check("hold_busy", 32'(busy), 32'd1);
    check("hold_addr_reset", 32'(wr_addr), 32'd0);
    spi_bits(32'hCD, 8);
    cs_high(8);
    check("hold_exit_state", 32'(state_dbg), 32'(IDLE));
    check("hold_wr_count", 32'(wr_cnt - wr0), 32'd0);
    check("hold_err_count", 32'(err_cnt - err0), 32'd0);
    exp_q.push_back(16'hF001);
    spi_frame(32'hF001, 16, 8);
    check("f001_wr_count", 32'(wr_cnt - wr0), 32'd1);
    check("f001_addr", 32'(wr_addr), 32'hF);
    check("f001_data", 32'(wr_data), 32'h001);

    // Back-to-back frames with minimum CS high gap
    wr0 = wr_cnt; err0 = err_cnt;
    exp_q.push_back(16'h1123);
    exp_q.push_back(16'h2456);
    spi_frame(32'h1123, 16, 3);
    spi_frame(32'h2456, 16, 8);
    check("b2b_wr_count", 32'(wr_cnt - wr0), 32'd2);
    check("b2b_err_count", 32'(err_cnt - err0), 32'd0);
    check("b2b_addr", 32'(wr_addr), 32'h2);
    check("b2b_data", 32'(wr_data), 32'h456);

    // SPI_CLK rising together with SPI_CS rising after 16 bits: extra edge ignored
    wr0 = wr_cnt; err0 = err_cnt;
    exp_q.push_back(16'h7E81);
    cs_low();
    spi_bits(32'h7E81, 16);
    spi_mosi = 1'b1;
    spi_cs   = 1'b1;
    spi_clk  = 1'b1;
    t_rise   = cyc;
    tick(4);
    spi_clk = 1'b0;
    tick(6);
    check("coinc_wr_count", 32'(wr_cnt - wr0), 32'd1);
    check("coinc_err_count", 32'(err_cnt - err0), 32'd0);
    check("coinc_latency", 32'(wr_cyc - t_rise), 32'd4);
    check("coinc_addr", 32'(wr_addr), 32'h7);
    check("coinc_data", 32'(wr_data), 32'hE81);

    tick(4);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
